// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: decodes command/data frames received through spi_slave,
// maintains an exported register file and stages read data on data_to_send.
// Optional feature macro: SPI_REG_AUTOINC_EN (burst writes with address
// auto-increment). Without it, one data byte is written per frame.
module spi_reg_ctrl #(
   parameter int NUM_REGS = 16
) (
   input  logic                  system_clk,
   input  logic                  system_rst_n,
   input  logic                  spi_cs,
   input  logic                  spi_data_ready,
   input  logic [7:0]            spi_rx_data,
   output logic                  spi_read_ack,
   output logic [7:0]            data_to_send,
   input  logic [7:0]            status_in,
   output logic [8*NUM_REGS-1:0] regs_out,
   output logic                  wr_strobe,
   output logic [6:0]            wr_addr,
   output logic                  err_flag
);

   localparam logic [6:0] NUM_REGS_A  = 7'(NUM_REGS);
   localparam logic [6:0] ADDR_ERR    = 7'h7E;
   localparam logic [6:0] ADDR_STATUS = 7'h7F;

   typedef enum logic [1:0] {ST_CMD, ST_DATA, ST_DRAIN} state_t;

   state_t     state_reg, state_next;
   logic       armed_reg, armed_next;
   logic       cs_sync1_reg, cs_sync2_reg, cs_prev_reg;
   logic       cs_rise;
   logic       accept;
   logic [6:0] rx_addr;
   logic [6:0] addr_reg, addr_next;
   logic       data_seen_reg, data_seen_next;
   logic [7:0] regs_reg [NUM_REGS];
   logic [7:0] reg_sel;
   logic       wr_en, rd_en, err_set, err_clr;
   logic [7:0] rd_data;

   assign rx_addr = spi_rx_data[6:0];
   // The cycle where ack is already high is skipped: the slave drops ready on that edge.
   assign accept  = spi_data_ready & ~spi_read_ack;
   assign cs_rise = cs_sync2_reg & ~cs_prev_reg;

   // CS synchronizer and rise detector; flops reset low so a CS that is idle
   // high at reset release arms the decoder, while a mid-frame reset waits for the frame end.
   always_ff @(posedge system_clk or negedge system_rst_n) begin
      if (!system_rst_n) begin
         cs_sync1_reg <= 1'b0;
         cs_sync2_reg <= 1'b0;
         cs_prev_reg  <= 1'b0;
      end else begin
         cs_sync1_reg <= spi_cs;
         cs_sync2_reg <= cs_sync1_reg;
         cs_prev_reg  <= cs_sync2_reg;
      end
   end

   // FSM state register; armed_reg gates command decoding until the first CS rise.
   always_ff @(posedge system_clk or negedge system_rst_n) begin
      if (!system_rst_n) begin
         state_reg <= ST_CMD;
         armed_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         armed_reg <= armed_next;
      end
   end

   // Next-state logic; a CS rise always wins so the byte of the same cycle is processed first.
   always_comb begin
      state_next = state_reg;
      armed_next = armed_reg;
      case (state_reg)
         ST_CMD: begin
            if (accept && armed_reg)
               state_next = spi_rx_data[7] ? ST_DRAIN : ST_DATA;
         end
         ST_DATA: begin
`ifdef SPI_REG_AUTOINC_EN
            state_next = ST_DATA;
`else
            if (accept)
               state_next = ST_DRAIN;
`endif
         end
         default: state_next = state_reg;
      endcase
      if (cs_rise) begin
         state_next = ST_CMD;
         armed_next = 1'b1;
      end
   end

   // Register-file read mux indexed by the incoming command address.
   always_comb begin
      reg_sel = 8'h00;
      for (int k = 0; k < NUM_REGS; k++)
         if (rx_addr == 7'(k))
            reg_sel = regs_reg[k];
   end

   // Output decode: write/read enables, error set/clear and address bookkeeping.
   always_comb begin
      wr_en          = 1'b0;
      rd_en          = 1'b0;
      rd_data        = 8'h00;
      err_set        = 1'b0;
      err_clr        = 1'b0;
      addr_next      = addr_reg;
      data_seen_next = data_seen_reg;
      case (state_reg)
         ST_CMD: begin
            if (accept && armed_reg) begin
               addr_next      = rx_addr;
               data_seen_next = 1'b0;
               if (spi_rx_data[7]) begin
                  rd_en = 1'b1;
                  if (rx_addr < NUM_REGS_A)
                     rd_data = reg_sel;
                  else if (rx_addr == ADDR_STATUS)
                     rd_data = status_in;
                  else if (rx_addr == ADDR_ERR) begin
                     rd_data = {7'b0, err_flag};
                     err_clr = 1'b1;
                  end else
                     err_set = 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (accept) begin
               data_seen_next = 1'b1;
               if (addr_reg < NUM_REGS_A) begin
                  wr_en = 1'b1;
`ifdef SPI_REG_AUTOINC_EN
                  addr_next = (addr_reg == NUM_REGS_A - 7'd1) ? 7'd0 : addr_reg + 7'd1;
`endif
               end else
                  err_set = 1'b1;
            end else if (cs_rise && !data_seen_reg)
               err_set = 1'b1;
         end
         default: ;
      endcase
   end

   // Registered outputs and address tracking; a new error beats a coincident clear.
   always_ff @(posedge system_clk or negedge system_rst_n) begin
      if (!system_rst_n) begin
         spi_read_ack  <= 1'b0;
         data_to_send  <= 8'h00;
         wr_strobe     <= 1'b0;
         wr_addr       <= 7'd0;
         err_flag      <= 1'b0;
         addr_reg      <= 7'd0;
         data_seen_reg <= 1'b0;
      end else begin
         spi_read_ack  <= accept;
         wr_strobe     <= wr_en;
         addr_reg      <= addr_next;
         data_seen_reg <= data_seen_next;
         if (wr_en)
            wr_addr <= addr_reg;
         if (rd_en)
            data_to_send <= rd_data;
         if (err_set)
            err_flag <= 1'b1;
         else if (err_clr)
            err_flag <= 1'b0;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
         // One register of the file, written when a committed write targets it.
         always_ff @(posedge system_clk or negedge system_rst_n) begin
            if (!system_rst_n)
               regs_reg[gi] <= 8'h00;
            else if (wr_en && addr_reg == 7'(gi))
               regs_reg[gi] <= spi_rx_data;
         end
         assign regs_out[8*gi +: 8] = regs_reg[gi];
      end
   endgenerate

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: scoreboard bench for spi_reg_ctrl with a frame-level
// reference model. Build with SPI_REG_AUTOINC_EN defined to cover burst writes.
module tb_spi_reg_ctrl;

   localparam int NUM_REGS = 16;
`ifdef SPI_REG_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   typedef logic [7:0] byte_q_t[$];
   typedef struct {
      bit         wr;
      logic [6:0] waddr;
      logic [7:0] wdata;
      logic [7:0] dts;
      bit         err;
   } exp_t;

   logic                  system_clk = 1'b0;
   logic                  system_rst_n = 1'b0;
   logic                  spi_cs = 1'b1;
   logic                  spi_data_ready = 1'b0;
   logic [7:0]            spi_rx_data = 8'h00;
   logic [7:0]            status_in = 8'h00;
   logic                  spi_read_ack;
   logic [7:0]            data_to_send;
   logic [8*NUM_REGS-1:0] regs_out;
   logic                  wr_strobe;
   logic [6:0]            wr_addr;
   logic                  err_flag;

   int checks = 0;
   int errors = 0;
   int issued = 0;
   int acks   = 0;

   exp_t exp_q[$];

   // reference model state
   logic [7:0] m_regs [NUM_REGS];
   bit         m_err;
   logic [7:0] m_dts;
   bit         m_armed;
   int         m_idx;
   logic [7:0] m_cmd;

   spi_reg_ctrl #(.NUM_REGS(NUM_REGS)) dut (
      .system_clk     (system_clk),
      .system_rst_n   (system_rst_n),
      .spi_cs         (spi_cs),
      .spi_data_ready (spi_data_ready),
      .spi_rx_data    (spi_rx_data),
      .spi_read_ack   (spi_read_ack),
      .data_to_send   (data_to_send),
      .status_in      (status_in),
      .regs_out       (regs_out),
      .wr_strobe      (wr_strobe),
      .wr_addr        (wr_addr),
      .err_flag       (err_flag)
   );

   always #5 system_clk = ~system_clk;

   task automatic check(input string name, input logic [8*NUM_REGS-1:0] act,
                        input logic [8*NUM_REGS-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic [8*NUM_REGS-1:0] model_vec();
      logic [8*NUM_REGS-1:0] v;
      v = '0;
      for (int k = 0; k < NUM_REGS; k++)
         v[8*k +: 8] = m_regs[k];
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NUM_REGS; k++)
         m_regs[k] = 8'h00;
      m_err   = 1'b0;
      m_dts   = 8'h00;
      m_armed = 1'b0;
      m_idx   = 0;
      m_cmd   = 8'h00;
   endtask

   // Effect of one accepted byte, judged by its position in the frame.
   task automatic model_byte(input logic [7:0] b);
      exp_t e;
      int   a;
      int   start;
      e.wr = 1'b0;
      e.waddr = 7'd0;
      e.wdata = 8'h00;
      if (m_armed) begin
         if (m_idx == 0) begin
            m_cmd = b;
            if (b[7]) begin
               a = int'(b[6:0]);
               if (a < NUM_REGS)
                  m_dts = m_regs[a];
               else if (a == 127)
                  m_dts = status_in;
               else if (a == 126) begin
                  m_dts = {7'b0, m_err};
                  m_err = 1'b0;
               end else begin
                  m_dts = 8'h00;
                  m_err = 1'b1;
               end
            end
         end else if (!m_cmd[7] && (m_idx == 1 || AUTOINC)) begin
            start = int'(m_cmd[6:0]);
            if (start < NUM_REGS) begin
               a = (start + m_idx - 1) % NUM_REGS;
               m_regs[a] = b;
               e.wr = 1'b1;
               e.waddr = 7'(a);
               e.wdata = b;
            end else
               m_err = 1'b1;
         end
         m_idx++;
      end
      e.dts = m_dts;
      e.err = m_err;
      exp_q.push_back(e);
   endtask

   task automatic model_frame_end();
      if (m_armed && m_idx == 1 && !m_cmd[7])
         m_err = 1'b1;
      m_armed = 1'b1;
      m_idx = 0;
   endtask

   // Present one byte like spi_slave: hold ready until the edge after the ack.
   task automatic send_byte(input logic [7:0] b);
      int waited;
      model_byte(b);
      issued++;
      @(negedge system_clk);
      spi_rx_data = b;
      spi_data_ready = 1'b1;
      waited = 0;
      do begin
         @(negedge system_clk);
         waited++;
      end while (!spi_read_ack && waited < 20);
      check("ack_seen", spi_read_ack, 1);
      if (!spi_read_ack) begin
         void'(exp_q.pop_back());
         spi_data_ready = 1'b0;
      end else begin
         @(posedge system_clk);
         #1 spi_data_ready = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(posedge system_clk);
   endtask

   task automatic check_frame_state(input string tag);
      check({tag, "_err"}, err_flag, m_err);
      check({tag, "_dts"}, data_to_send, m_dts);
      check({tag, "_regs"}, regs_out, model_vec());
   endtask

   task automatic run_frame(input byte_q_t bytes, input logic [7:0] status);
      status_in = status;
      @(negedge system_clk);
      spi_cs = 1'b0;
      repeat (3) @(negedge system_clk);
      foreach (bytes[i])
         send_byte(bytes[i]);
      @(negedge system_clk);
      spi_cs = 1'b1;
      model_frame_end();
      repeat (5) @(negedge system_clk);
      check_frame_state("frame");
   endtask

   // Monitor: every ack pulse retires one expectation from the scoreboard.
   initial begin : monitor
      bit   prev_ack;
      exp_t e;
      prev_ack = 1'b0;
      forever begin
         @(negedge system_clk);
         if (system_rst_n) begin
            if (spi_read_ack) begin
               acks++;
               check("ack_width", prev_ack, 0);
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL ack_unexpected: ack with empty scoreboard");
               end else begin
                  e = exp_q.pop_front();
                  check("wr_strobe", wr_strobe, e.wr);
                  if (e.wr) begin
                     check("wr_addr", wr_addr, e.waddr);
                     check("reg_write", regs_out[int'(e.waddr)*8 +: 8], e.wdata);
                  end
                  check("data_to_send", data_to_send, e.dts);
                  check("err_flag", err_flag, e.err);
               end
            end else if (wr_strobe) begin
               checks++;
               errors++;
               $display("FAIL stray_strobe: wr_strobe=1 without ack, wr_addr=%0h", wr_addr);
            end
         end
         prev_ack = spi_read_ack;
      end
   end

   initial begin : stimulus
      byte_q_t    fr;
      int         len;
      logic [7:0] cmd;

      model_reset();
      repeat (3) @(negedge system_clk);
      check("rst_ack", spi_read_ack, 0);
      check("rst_dts", data_to_send, 0);
      check("rst_regs", regs_out, 0);
      check("rst_strobe", wr_strobe, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_err", err_flag, 0);
      system_rst_n = 1'b1;
      m_armed = 1'b1;   // CS idle high at release counts as a frame boundary
      repeat (6) @(negedge system_clk);

      run_frame('{8'h03, 8'hA5}, 8'h00);
      check("write_reg3", regs_out[31:24], 8'hA5);
      run_frame('{8'h83}, 8'h00);
      check("readback", data_to_send, 8'hA5);
      run_frame('{8'hFF}, 8'h5C);
      check("status_read", data_to_send, 8'h5C);
      run_frame('{8'h20, 8'h11}, 8'h00);
      check("oor_err", err_flag, 1);
      run_frame('{8'hFE}, 8'h00);
      check("err_read", data_to_send, 8'h01);
      check("err_cleared", err_flag, 0);
      run_frame('{8'h05}, 8'h00);
      check("abort_err", err_flag, 1);
      run_frame('{8'hFE}, 8'h00);
      run_frame('{8'h0F, 8'h01, 8'h02}, 8'h00);
      check("burst_reg15", regs_out[127:120], 8'h01);
      check("burst_reg0", regs_out[7:0], AUTOINC ? 8'h02 : 8'h00);

      for (int f = 0; f < 60; f++) begin
         fr = {};
         case ($urandom_range(0, 3))
            0, 1:    cmd = {1'b0, 7'($urandom_range(0, NUM_REGS + 1))};
            2:       cmd = {1'b1, 7'($urandom_range(0, NUM_REGS - 1))};
            default: cmd = {1'b1, 7'($urandom_range(124, 127))};
         endcase
         fr.push_back(cmd);
         len = $urandom_range(1, 4);
         for (int i = 1; i < len; i++)
            fr.push_back(8'($urandom));
         run_frame(fr, 8'($urandom));
      end

      // reset in the middle of a write frame
      status_in = 8'h00;
      @(negedge system_clk);
      spi_cs = 1'b0;
      repeat (3) @(negedge system_clk);
      send_byte(8'h02);
      @(negedge system_clk);
      system_rst_n = 1'b0;
      model_reset();
      #1;
      check("mid_rst_ack", spi_read_ack, 0);
      check("mid_rst_dts", data_to_send, 0);
      check("mid_rst_regs", regs_out, 0);
      check("mid_rst_strobe", wr_strobe, 0);
      check("mid_rst_wr_addr", wr_addr, 0);
      check("mid_rst_err", err_flag, 0);
      repeat (2) @(negedge system_clk);
      system_rst_n = 1'b1;
      repeat (3) @(negedge system_clk);
      send_byte(8'h77);
      @(negedge system_clk);
      spi_cs = 1'b1;
      model_frame_end();
      repeat (5) @(negedge system_clk);
      check_frame_state("post_rst");
      run_frame('{8'h02, 8'h3C}, 8'h00);
      check("post_rst_write", regs_out[23:16], 8'h3C);

      repeat (4) @(negedge system_clk);
      check("scoreboard_empty", exp_q.size(), 0);
      check("ack_count", acks, issued);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
